// File: rtl/ssd1306_pkg.sv
// Shared constants and types for the SSD1306 text path.
// Font geometry, ROM addressing and glyph-streamer FSM states.
package ssd1306_pkg;

  localparam int          GLYPH_W      = 8;
  localparam int          LINE_CHARS   = 16;
  localparam int          DISPLAY_COLS = 128;
  localparam int          FONT_ADDR_W  = 11;
  localparam int          FIFO_DEPTH   = 2;
  localparam logic [7:0]  SUBST_CHAR   = 8'h3F;

  typedef enum logic {
    IDLE,
    FETCH
  } state_e;

endpackage

// File: rtl/char_glyph_streamer_fifo.sv
// byte_fifo: small synchronous FIFO with count and sync clear.
// Ports: clk, rst_n, clr, push/din, pop/dout, count, empty.
module byte_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 9,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [W-1:0]    din,
  input  logic            pop,
  output logic [W-1:0]    dout,
  output logic [CNTW-1:0] count,
  output logic            empty
);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CNTW-1:0] cnt_q;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= din;
        wr_q      <= nxt(wr_q);
      end
      if (pop)
        rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
    end
  end

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  // Empty FIFO presents zeros rather than a stale entry.
  assign dout  = empty ? '0 : mem[rd_q];

endmodule

// File: rtl/char_glyph_streamer.sv
// char_glyph_streamer: ASCII codes in, font-ROM column bytes out.
// Ports: char_* stream in, rom_* font ROM, px_* byte stream out.
module char_glyph_streamer #(
  parameter int         GLYPH_W    = ssd1306_pkg::GLYPH_W,
  parameter int         LINE_CHARS = ssd1306_pkg::LINE_CHARS,
  parameter logic [7:0] SUBST_CHAR = ssd1306_pkg::SUBST_CHAR,
  parameter int         FIFO_DEPTH = ssd1306_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        char_valid,
  input  logic [7:0]  char_code,
  output logic        char_ready,
  output logic        rom_en,
  output logic [ssd1306_pkg::FONT_ADDR_W-1:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        px_valid,
  output logic [7:0]  px_data,
  output logic        px_last,
  input  logic        px_ready
);

  import ssd1306_pkg::*;

  localparam int CW   = $clog2(GLYPH_W);
  localparam int LW   = $clog2(LINE_CHARS);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   col_q;
  logic [6:0]      glyph_q;
  logic [LW-1:0]   line_q;
  logic            rdy_q;
  logic            infl_q;
  logic            infl_last_q;

  logic            hs;
  logic            issue;
  logic            last_col;
  logic            last_char;
  logic            credit;
  logic            pop;
  logic            push;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_empty;
  logic [8:0]      fifo_dout;

  assign hs        = char_valid & rdy_q;
  assign pop       = px_valid & px_ready;
  assign push      = infl_q & ~clr;
  assign last_col  = (col_q == CW'(GLYPH_W - 1));
  assign last_char = (line_q == LW'(LINE_CHARS - 1));

  // A byte leaving this cycle frees its slot, so reads
  // stay back-to-back while downstream keeps up.
  assign credit = (int'(fifo_count) + int'(infl_q)
                   - int'(pop)) < FIFO_DEPTH;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs)
          state_d = FETCH;
      end
      FETCH: begin
        issue = credit;
        if (credit && last_col)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr)
      state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      glyph_q     <= '0;
      line_q      <= '0;
      rdy_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= (state_d == IDLE) & ~clr;
      infl_q      <= issue & ~clr;
      infl_last_q <= issue & last_col & last_char & ~clr;
      if (clr) begin
        col_q  <= '0;
        line_q <= '0;
      end else if (hs) begin
        glyph_q <= char_code[7] ? SUBST_CHAR[6:0]
                                : char_code[6:0];
        col_q   <= '0;
      end else if (issue) begin
        col_q <= col_q + CW'(1);
        if (last_col)
          line_q <= last_char ? '0 : line_q + LW'(1);
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   ({infl_last_q, rom_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign char_ready         = rdy_q;
  assign rom_en             = issue;
  assign rom_addr           = FONT_ADDR_W'({glyph_q, col_q});
  assign px_valid           = ~fifo_empty;
  assign {px_last, px_data} = fifo_dout;

endmodule
